mult_unit: RTL and testbench

- Sequential radix-2 shift-add multiplier that produces the 64-bit hi/lo product consumed by the register file's hi/lo write path (the isMult path).
- Sits directly downstream of the operand-selection stage, beside the ALU; replaces the single-cycle combinational multiply.
- Accepts one operation at a time through a start/busy/done handshake and holds the last result until the next completion.

---
 rtl/mult_unit.sv | 108 ++++++++++
 tb/tb_mult_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// Sequential radix-2 shift-add multiplier.
// Feeds the hi/lo write path with a 2*WIDTH-bit product.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_value,
  output logic [WIDTH-1:0] lo_value
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SIGN,
    DONE
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] result;

  // Operand magnitudes at acceptance and the sign-corrected product.
  always_comb begin
    mag_a  = operand_a;
    mag_b  = operand_b;
    result = acc;
    if (is_signed && operand_a[WIDTH-1])
      mag_a = -operand_a;
    if (is_signed && operand_b[WIDTH-1])
      mag_b = -operand_b;
    if (neg)
      result = -acc;
  end

  // Control FSM and datapath: one multiplier bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi_value <= '0;
      lo_value <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            cnt    <= CW'(WIDTH - 1);
            neg    <= is_signed
                    & (operand_a[WIDTH-1]
                    ^ operand_b[WIDTH-1]);
          end
        end
        RUN: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == '0)
            state <= SIGN;
        end
        SIGN: begin
          {hi_value, lo_value} <= result;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Bench for mult_unit: scoreboard queue of expected
// products, drained by a monitor on each done pulse.
module tb_mult_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi_value;
  logic [W-1:0] lo_value;

  typedef struct {
    logic [2*W-1:0] prod;
    int             t0;
  } exp_t;

  exp_t           sb[$];
  int             n_pass;
  int             n_total;
  int             cyc;
  bit             rst_seen;
  bit             mon_en;
  int             busy_n;
  logic [2*W-1:0] prev;

  mult_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hi_value  (hi_value),
    .lo_value  (lo_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  function automatic logic [2*W-1:0] ref_mul(
    input bit s, input logic [W-1:0] a,
    input logic [W-1:0] b);
    longint sa;
    longint sb_;
    logic [2*W-1:0] ua;
    logic [2*W-1:0] ub;
    if (s) begin
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      return 64'(sa * sb_);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  // Monitor: pops on each done, checks product,
  // latency, busy length and hi/lo stability.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) begin
        busy_n = 0;
      end else begin
        if (busy) busy_n++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("product", {hi_value, lo_value}, e.prod);
            chk("latency", 64'(cyc - e.t0), 64'(W + 1));
            chk("busy_len", 64'(busy_n), 64'(W + 1));
            chk("busy_at_done", 64'(busy), 64'd0);
          end
          busy_n = 0;
        end else begin
          chk("hold", {hi_value, lo_value}, prev);
        end
      end
      prev = {hi_value, lo_value};
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && !done) return;
    end
    chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input bit s,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    exp_t e;
    wait_idle();
    start     = 1'b1;
    is_signed = s;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    e.prod = ref_mul(s, a, b);
    e.t0   = cyc;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic run(input bit s,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b);
    issue(s, a, b);
    wait_done();
  endtask

  // Issue one op, then scramble inputs through
  // RUN, SIGN and DONE; none of it may be taken.
  task automatic noisy(input bit s,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    issue(s, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      operand_a = $urandom;
      operand_b = $urandom;
      is_signed = 1'($urandom);
      if (done) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        return;
      end
      start = 1'($urandom);
    end
    start = 1'b0;
    chk("noisy_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] t [6];
    t[0] = 32'h0000_0000;
    t[1] = 32'h0000_0001;
    t[2] = 32'hFFFF_FFFF;
    t[3] = 32'h8000_0000;
    t[4] = 32'h7FFF_FFFF;
    t[5] = $urandom;
    return t[$urandom_range(0, 5)];
  endfunction

  initial begin
    n_pass = 0;
    n_total = 0;
    cyc = 0;
    mon_en = 0;
    busy_n = 0;
    prev = '0;
    rst_n = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    operand_a = '0;
    operand_b = '0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi_value, lo_value}, 64'd0);
    prev = {hi_value, lo_value};
    mon_en = 1;
    repeat (10) @(negedge clk);
    chk("idle_hilo", {hi_value, lo_value}, 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("umax", {hi_value, lo_value},
        64'hFFFF_FFFE_0000_0001);
    run(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("neg1x1", {hi_value, lo_value},
        64'hFFFF_FFFF_FFFF_FFFF);
    run(1'b1, 32'h8000_0000, 32'h8000_0000);
    chk("minxmin", {hi_value, lo_value},
        64'h4000_0000_0000_0000);
    run(1'b1, 32'hFFFF_FFFD, 32'h0000_0007);
    chk("neg3x7", {hi_value, lo_value},
        64'hFFFF_FFFF_FFFF_FFEB);

    run(1'b1, 32'h0000_0000, 32'h8000_0000);
    repeat (20) @(negedge clk);
    chk("zero_hold", {hi_value, lo_value}, 64'd0);
    run(1'b0, 32'h0001_2345, 32'h0001_0000);
    repeat (20) @(negedge clk);
    chk("u_hold", {hi_value, lo_value},
        64'h0000_0001_2345_0000);

    noisy(1'b1, 32'hFFFF_FFF0, 32'h0000_1234);
    repeat (3) @(negedge clk);
    chk("noise_res", {hi_value, lo_value},
        ref_mul(1'b1, 32'hFFFF_FFF0, 32'h0000_1234));

    issue(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_hilo", {hi_value, lo_value}, 64'd0);
    repeat (40) @(negedge clk);
    run(1'b0, 32'h0000_0006, 32'h0000_0007);
    chk("after_rst", {hi_value, lo_value},
        64'h0000_0000_0000_002A);

    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 0)
        noisy(1'($urandom), pick(), pick());
      else
        run(1'($urandom), pick(), pick());
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
